nn_layer_sequencer: RTL

Sequences one inference pass through the network's layer engines once the staged reset sequence has finished. It issues a one-cycle start pulse to each layer in order and waits for that layer's done before launching the next. A per-layer watchdog flags a stalled layer, and the block counts completed inferences. It sits between the staged reset controller (its `init_complete` input) and the layer datapaths.

---
 rtl/nn_layer_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/nn_layer_sequencer.sv
// Runs one inference pass through NUM_LAYERS layer engines: start pulse, wait for done,
// next layer. A per-layer watchdog raises a sticky fault; completed passes are counted.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = 1023,
  parameter int TO_W       = 10,
  parameter int CNT_W      = 16,
  localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  ext_reset,
  input  logic                  init_complete,
  input  logic                  start,
  input  logic                  clear_err,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [LW-1:0]         cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LW-1:0]         err_layer,
  output logic [CNT_W-1:0]      inf_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [LW-1:0]   LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [TO_W-1:0] WD_LIMIT   = TO_W'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [LW-1:0]           cur_layer_q, cur_layer_d;
  logic [LW-1:0]           err_layer_q, err_layer_d;
  logic [TO_W-1:0]         wd_q, wd_d;
  logic [CNT_W-1:0]        inf_count_q, inf_count_d;
  logic                    error_q, error_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_LAYERS-1:0]   layer_start_q, layer_start_d;

  always_comb begin
    state_d       = state_q;
    cur_layer_d   = cur_layer_q;
    err_layer_d   = err_layer_q;
    wd_d          = wd_q;
    inf_count_d   = inf_count_q;
    error_d       = error_q;
    layer_start_d = '0;

    case (state_q)
      S_IDLE: begin
        if (init_complete && start) begin
          cur_layer_d = '0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!init_complete) begin
          state_d = S_IDLE;
        end else begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Losing init beats a done or a timeout in the same cycle; done beats timeout.
        if (!init_complete) begin
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + TO_W'(1);
          if (layer_done[cur_layer_q]) begin
            if (cur_layer_q == LAST_LAYER) begin
              state_d = S_FINISH;
            end else begin
              cur_layer_d = cur_layer_q + LW'(1);
              state_d     = S_LAUNCH;
            end
          end else if (wd_q == WD_LIMIT) begin
            err_layer_d = cur_layer_q;
            error_d     = 1'b1;
            state_d     = S_FAULT;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (init_complete) begin
          inf_count_d = inf_count_q + CNT_W'(1);
        end
      end
      S_FAULT: begin
        if (clear_err) begin
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    if (state_d == S_LAUNCH) begin
      layer_start_d[cur_layer_d] = 1'b1;
    end
    busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (ext_reset) begin
      state_q       <= S_IDLE;
      cur_layer_q   <= '0;
      err_layer_q   <= '0;
      wd_q          <= '0;
      inf_count_q   <= '0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      layer_start_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_layer_q   <= cur_layer_d;
      err_layer_q   <= err_layer_d;
      wd_q          <= wd_d;
      inf_count_q   <= inf_count_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      layer_start_q <= layer_start_d;
    end
  end

  assign layer_start = layer_start_q;
  assign cur_layer   = cur_layer_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_layer   = err_layer_q;
  assign inf_count   = inf_count_q;
  assign dbg_state   = state_q;

endmodule
